// File: rtl/mem_sched.sv
// Two-port load/store scheduler: round-robin arbitration in front of a single
// word-wide synchronous memory, with sub-word lane steering and load extension.
module mem_sched (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [1:0]  req_i,
    input  logic [1:0]  we_i,
    input  logic [1:0]  sext_i,
    input  logic [1:0]  size0_i,
    input  logic [1:0]  size1_i,
    input  logic [31:0] addr0_i,
    input  logic [31:0] addr1_i,
    input  logic [31:0] wdata0_i,
    input  logic [31:0] wdata1_i,
    output logic [1:0]  gnt_o,
    output logic [1:0]  done_o,
    output logic [1:0]  err_o,
    output logic [31:0] rdata_o,
    output logic        m_en_o,
    output logic [3:0]  m_be_o,
    output logic [31:0] m_addr_o,
    output logic [31:0] m_wdata_o,
    input  logic [31:0] m_rdata_i
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t      state_q;
    logic        ready_q;
    logic        prio_q;
    logic        port_q;
    logic        we_q;
    logic        sext_q;
    logic [1:0]  size_q;
    logic [1:0]  off_q;
    logic        m_en_q;
    logic [3:0]  m_be_q;
    logic [31:0] m_addr_q;
    logic [31:0] m_wdata_q;
    logic [1:0]  done_q;
    logic [1:0]  err_q;

    logic        win_d;
    logic        sel_we_d;
    logic        sel_sext_d;
    logic [1:0]  sel_size_d;
    logic [31:0] sel_addr_d;
    logic [31:0] sel_wdata_d;
    logic        bad_d;
    logic [3:0]  be_d;
    logic [31:0] wdata_rep_d;
    logic        can_grant_d;
    logic [1:0]  win_onehot_d;

    // With both requesting, the port favoured by the pointer wins.
    assign win_d        = (&req_i) ? prio_q : req_i[1];
    assign win_onehot_d = win_d ? 2'b10 : 2'b01;
    // ready_q holds off any grant until the first edge after reset release.
    assign can_grant_d  = (state_q == IDLE) && ready_q && (|req_i);
    assign gnt_o        = can_grant_d ? win_onehot_d : 2'b00;

    assign sel_we_d    = we_i[win_d];
    assign sel_sext_d  = sext_i[win_d];
    assign sel_size_d  = win_d ? size1_i  : size0_i;
    assign sel_addr_d  = win_d ? addr1_i  : addr0_i;
    assign sel_wdata_d = win_d ? wdata1_i : wdata0_i;

    always_comb begin
        bad_d       = 1'b0;
        be_d        = 4'b0000;
        wdata_rep_d = 32'h0;
        case (sel_size_d)
            2'd0: begin
                bad_d       = (sel_addr_d[1:0] != 2'b00);
                be_d        = 4'b1111;
                wdata_rep_d = sel_wdata_d;
            end
            2'd1: begin
                bad_d       = sel_addr_d[0];
                be_d        = sel_addr_d[1] ? 4'b1100 : 4'b0011;
                wdata_rep_d = {2{sel_wdata_d[15:0]}};
            end
            2'd2: begin
                be_d        = 4'b0001 << sel_addr_d[1:0];
                wdata_rep_d = {4{sel_wdata_d[7:0]}};
            end
            default: begin
                bad_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            ready_q   <= 1'b0;
            prio_q    <= 1'b0;
            port_q    <= 1'b0;
            we_q      <= 1'b0;
            sext_q    <= 1'b0;
            size_q    <= 2'd0;
            off_q     <= 2'd0;
            m_en_q    <= 1'b0;
            m_be_q    <= 4'b0000;
            m_addr_q  <= 32'h0;
            m_wdata_q <= 32'h0;
            done_q    <= 2'b00;
            err_q     <= 2'b00;
        end else begin
            ready_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (can_grant_d) begin
                        port_q <= win_d;
                        prio_q <= ~win_d;
                        we_q   <= sel_we_d;
                        sext_q <= sel_sext_d;
                        size_q <= sel_size_d;
                        off_q  <= sel_addr_d[1:0];
                        if (bad_d) begin
                            // Faulting accesses never touch memory.
                            state_q <= RESP;
                            done_q  <= win_onehot_d;
                            err_q   <= win_onehot_d;
                        end else begin
                            state_q   <= ACCESS;
                            m_en_q    <= 1'b1;
                            m_be_q    <= sel_we_d ? be_d : 4'b0000;
                            m_addr_q  <= {sel_addr_d[31:2], 2'b00};
                            m_wdata_q <= sel_we_d ? wdata_rep_d : 32'h0;
                        end
                    end
                end
                ACCESS: begin
                    state_q   <= RESP;
                    m_en_q    <= 1'b0;
                    m_be_q    <= 4'b0000;
                    m_addr_q  <= 32'h0;
                    m_wdata_q <= 32'h0;
                    done_q    <= port_q ? 2'b10 : 2'b01;
                    err_q     <= 2'b00;
                end
                RESP: begin
                    state_q <= IDLE;
                    done_q  <= 2'b00;
                    err_q   <= 2'b00;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign m_en_o    = m_en_q;
    assign m_be_o    = m_be_q;
    assign m_addr_o  = m_addr_q;
    assign m_wdata_o = m_wdata_q;
    assign done_o    = done_q;
    assign err_o     = err_q;

    // Memory data arrives during RESP, so extraction is combinational there.
    logic [15:0] half_lane;
    logic [7:0]  byte_lane;

    always_comb begin
        half_lane = off_q[1] ? m_rdata_i[31:16] : m_rdata_i[15:0];
        case (off_q)
            2'd0:    byte_lane = m_rdata_i[7:0];
            2'd1:    byte_lane = m_rdata_i[15:8];
            2'd2:    byte_lane = m_rdata_i[23:16];
            default: byte_lane = m_rdata_i[31:24];
        endcase
        rdata_o = 32'h0;
        if ((state_q == RESP) && !we_q && (err_q == 2'b00)) begin
            case (size_q)
                2'd0:    rdata_o = m_rdata_i;
                2'd1:    rdata_o = {{16{sext_q & half_lane[15]}}, half_lane};
                2'd2:    rdata_o = {{24{sext_q & byte_lane[7]}}, byte_lane};
                default: rdata_o = 32'h0;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_sched.sv
// Directed bench for mem_sched: single transactions with hand-computed results,
// reset behaviour, and round-robin alternation under continuous contention.
module tb_mem_sched;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [1:0]  req_i, we_i, sext_i;
    logic [1:0]  size0_i, size1_i;
    logic [31:0] addr0_i, addr1_i, wdata0_i, wdata1_i;
    logic [1:0]  gnt_o, done_o, err_o;
    logic [31:0] rdata_o;
    logic        m_en_o;
    logic [3:0]  m_be_o;
    logic [31:0] m_addr_o, m_wdata_o;
    logic [31:0] m_rdata_i;

    int checks   = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    mem_sched dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .req_i     (req_i),
        .we_i      (we_i),
        .sext_i    (sext_i),
        .size0_i   (size0_i),
        .size1_i   (size1_i),
        .addr0_i   (addr0_i),
        .addr1_i   (addr1_i),
        .wdata0_i  (wdata0_i),
        .wdata1_i  (wdata1_i),
        .gnt_o     (gnt_o),
        .done_o    (done_o),
        .err_o     (err_o),
        .rdata_o   (rdata_o),
        .m_en_o    (m_en_o),
        .m_be_o    (m_be_o),
        .m_addr_o  (m_addr_o),
        .m_wdata_o (m_wdata_o),
        .m_rdata_i (m_rdata_i)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic set_port(input int p, input logic we, input logic sext,
                            input logic [1:0] size, input logic [31:0] addr,
                            input logic [31:0] wdata);
        if (p == 0) begin
            we_i[0] = we; sext_i[0] = sext; size0_i = size; addr0_i = addr; wdata0_i = wdata;
        end else begin
            we_i[1] = we; sext_i[1] = sext; size1_i = size; addr1_i = addr; wdata1_i = wdata;
        end
        req_i[p] = 1'b1;
    endtask

    // One isolated access; drive just after a rising edge, sample on falling edges.
    task automatic xact(input string name, input int p, input logic we, input logic sext,
                        input logic [1:0] size, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] mrd, input logic bad, input logic [3:0] ebe,
                        input logic [31:0] eaddr, input logic [31:0] ewd, input logic [31:0] erd);
        logic [1:0] oh;
        oh = (p == 0) ? 2'b01 : 2'b10;
        @(posedge clk_i); #1;
        set_port(p, we, sext, size, addr, wdata);
        m_rdata_i = mrd;
        @(negedge clk_i);
        chk({name, ".gnt"}, {30'h0, gnt_o}, {30'h0, oh});
        @(posedge clk_i); #1;
        req_i = 2'b00;
        @(negedge clk_i);
        if (!bad) begin
            chk({name, ".m_en"},    {31'h0, m_en_o}, 32'h1);
            chk({name, ".m_be"},    {28'h0, m_be_o}, {28'h0, ebe});
            chk({name, ".m_addr"},  m_addr_o, eaddr);
            chk({name, ".m_wdata"}, m_wdata_o, ewd);
            chk({name, ".done_acc"}, {30'h0, done_o}, 32'h0);
            @(negedge clk_i);
        end
        chk({name, ".done"},  {30'h0, done_o}, {30'h0, oh});
        chk({name, ".err"},   {30'h0, err_o}, bad ? {30'h0, oh} : 32'h0);
        chk({name, ".rdata"}, rdata_o, erd);
        chk({name, ".m_en_resp"}, {31'h0, m_en_o}, 32'h0);
        @(negedge clk_i);
        chk({name, ".done_idle"}, {30'h0, done_o}, 32'h0);
        $display("xact %s port=%0d we=%0d size=%0d addr=%h rdata=%h err=%b",
                 name, p, we, size, addr, erd, bad);
    endtask

    initial begin
        rst_ni = 1'b0;
        req_i = 2'b00; we_i = 2'b00; sext_i = 2'b00;
        size0_i = 2'd0; size1_i = 2'd0;
        addr0_i = 32'h0; addr1_i = 32'h0; wdata0_i = 32'h0; wdata1_i = 32'h0;
        m_rdata_i = 32'h0;

        // Request held through reset: nothing may be granted or driven.
        set_port(0, 1'b1, 1'b0, 2'd0, 32'h0000_0010, 32'h1122_3344);
        #2;
        chk("rst.gnt",   {30'h0, gnt_o}, 32'h0);
        chk("rst.done",  {30'h0, done_o}, 32'h0);
        chk("rst.err",   {30'h0, err_o}, 32'h0);
        chk("rst.rdata", rdata_o, 32'h0);
        chk("rst.m_en",  {31'h0, m_en_o}, 32'h0);
        chk("rst.m_be",  {28'h0, m_be_o}, 32'h0);
        chk("rst.m_addr", m_addr_o, 32'h0);
        chk("rst.m_wdata", m_wdata_o, 32'h0);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        chk("rel.gnt_before_edge", {30'h0, gnt_o}, 32'h0);
        @(negedge clk_i);
        chk("rel.gnt_first", {30'h0, gnt_o}, 32'h1);
        @(posedge clk_i); #1;
        req_i = 2'b00;
        chk("abort.m_en_pre", {31'h0, m_en_o}, 32'h1);
        chk("abort.m_be_pre", {28'h0, m_be_o}, 32'hF);
        #2 rst_ni = 1'b0;
        #1;
        chk("abort.m_en",  {31'h0, m_en_o}, 32'h0);
        chk("abort.m_be",  {28'h0, m_be_o}, 32'h0);
        chk("abort.m_addr", m_addr_o, 32'h0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk("abort.done1", {30'h0, done_o}, 32'h0);
        @(negedge clk_i);
        chk("abort.done2", {30'h0, done_o}, 32'h0);
        chk("abort.m_en2", {31'h0, m_en_o}, 32'h0);
        $display("xact reset_abort store port=0");

        //   name        p we sx sz addr          wdata         m_rdata       bad be     m_addr        m_wdata       rdata
        xact("st_word",  0, 1, 0, 0, 32'h0000_0010, 32'h1122_3344, 32'h0,        0, 4'hF, 32'h0000_0010, 32'h1122_3344, 32'h0);
        xact("ld_b_sx",  1, 0, 1, 2, 32'h0000_0023, 32'h0,        32'h80FF_7F01, 0, 4'h0, 32'h0000_0020, 32'h0,        32'hFFFF_FF80);
        xact("ld_b_zx",  1, 0, 0, 2, 32'h0000_0023, 32'h0,        32'h80FF_7F01, 0, 4'h0, 32'h0000_0020, 32'h0,        32'h0000_0080);
        xact("ld_h_hi",  0, 0, 1, 1, 32'h0000_0022, 32'h0,        32'h8001_7FFF, 0, 4'h0, 32'h0000_0020, 32'h0,        32'hFFFF_8001);
        xact("ld_h_lo",  0, 0, 1, 1, 32'h0000_0020, 32'h0,        32'h8001_7FFF, 0, 4'h0, 32'h0000_0020, 32'h0,        32'h0000_7FFF);
        xact("ld_b1_sx", 1, 0, 1, 2, 32'h0000_0021, 32'h0,        32'h80FF_7F01, 0, 4'h0, 32'h0000_0020, 32'h0,        32'h0000_007F);
        xact("st_half",  1, 1, 0, 1, 32'h0000_0012, 32'h0000_ABCD, 32'h0,        0, 4'hC, 32'h0000_0010, 32'hABCD_ABCD, 32'h0);
        xact("st_byte",  0, 1, 0, 2, 32'h0000_0031, 32'hFFFF_FF5A, 32'h0,        0, 4'h2, 32'h0000_0030, 32'h5A5A_5A5A, 32'h0);
        xact("ld_word",  1, 0, 0, 0, 32'h0000_0044, 32'h0,        32'hDEAD_BEEF, 0, 4'h0, 32'h0000_0044, 32'h0,        32'hDEAD_BEEF);
        xact("sz_ill",   1, 0, 0, 3, 32'h0000_0040, 32'h0,        32'hDEAD_BEEF, 1, 4'h0, 32'h0,         32'h0,        32'h0);
        xact("w_misal",  0, 0, 0, 0, 32'h0000_0042, 32'h0,        32'hDEAD_BEEF, 1, 4'h0, 32'h0,         32'h0,        32'h0);
        xact("h_misal",  0, 1, 0, 1, 32'h0000_0011, 32'h0000_1234, 32'h0,        1, 4'h0, 32'h0,         32'h0,        32'h0);

        // Last grant went to port 0; reset must restore the preference for port 0.
        @(negedge clk_i);
        rst_ni = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
        set_port(0, 1'b0, 1'b0, 2'd0, 32'h0000_0100, 32'h0);
        set_port(1, 1'b0, 1'b0, 2'd0, 32'h0000_0200, 32'h0);
        m_rdata_i = 32'h0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_i);
            chk($sformatf("rr.gnt%0d", k), {30'h0, gnt_o}, (k % 2 == 0) ? 32'h1 : 32'h2);
            @(negedge clk_i);
            chk($sformatf("rr.idle_a%0d", k), {30'h0, gnt_o}, 32'h0);
            @(negedge clk_i);
            chk($sformatf("rr.idle_b%0d", k), {30'h0, gnt_o}, 32'h0);
            $display("xact rr grant %0d to port=%0d", k, k % 2);
        end
        req_i = 2'b00;
        repeat (3) @(negedge clk_i);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
